// File: rtl/vx_commit_arbiter.sv
// vx_commit_arbiter: round-robin arbiter sharing one commit port among NUM_REQS
// execute-unit streams, with packet locking and a 2-entry registered output skid buffer.
module vx_commit_arbiter #(
    parameter int NUM_REQS   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int SEL_WIDTH  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            req_valid,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQS-1:0]            req_eop,
    output logic [NUM_REQS-1:0]            req_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_eop,
    output logic [SEL_WIDTH-1:0]           out_sel,
    input  logic                           out_ready,
    output logic                           lock_busy
);

    localparam int unsigned NREQ = NUM_REQS;

    logic [SEL_WIDTH-1:0]  ptr;
    logic                  lock;
    logic [SEL_WIDTH-1:0]  lock_idx;
    logic [1:0]            count;

    logic [DATA_WIDTH-1:0] tail_data;
    logic                  tail_eop;
    logic [SEL_WIDTH-1:0]  tail_sel;

    logic [SEL_WIDTH-1:0]  scan_idx;
    logic                  scan_found;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic                  grant_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_eop;
    logic                  buf_full;
    logic                  push;
    logic                  pop;

    // Round-robin scan from ptr, overridden by the lock holder while a packet is open.
    always_comb begin
        int unsigned idx;
        scan_idx    = ptr;
        scan_found  = 1'b0;
        grant_valid = 1'b0;
        in_data     = '0;
        in_eop      = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!scan_found && (i == idx) && req_valid[i]) begin
                    scan_found = 1'b1;
                    scan_idx   = SEL_WIDTH'(i);
                end
            end
        end
        grant_idx = lock ? lock_idx : scan_idx;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (32'(grant_idx) == i) begin
                grant_valid = req_valid[i];
                in_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                in_eop      = req_eop[i];
            end
        end
    end

    assign buf_full  = (count == 2'd2);
    assign push      = grant_valid && !buf_full && !reset;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign lock_busy = lock;

    // Ready is granted only to the winner; depends on registered buffer state, not out_ready.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = push && (32'(grant_idx) == i);
        end
    end

    // Lock and round-robin pointer update on each accepted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (push) begin
            if (in_eop) begin
                lock <= 1'b0;
                if (32'(grant_idx) == NREQ - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_idx + SEL_WIDTH'(1);
                end
            end else begin
                lock     <= 1'b1;
                lock_idx <= grant_idx;
            end
        end
    end

    // Two-entry skid buffer: head entry is the output register, tail absorbs one stall beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 2'd0;
            out_data  <= '0;
            out_eop   <= 1'b0;
            out_sel   <= '0;
            tail_data <= '0;
            tail_eop  <= 1'b0;
            tail_sel  <= '0;
        end else begin
            if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                out_data <= in_data;
                out_eop  <= in_eop;
                out_sel  <= grant_idx;
            end else if (pop && (count == 2'd2)) begin
                out_data <= tail_data;
                out_eop  <= tail_eop;
                out_sel  <= tail_sel;
            end
            if (push && (count == 2'd1) && !pop) begin
                tail_data <= in_data;
                tail_eop  <= in_eop;
                tail_sel  <= grant_idx;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (!push && pop) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule
